// File: rtl/tva_pkg.sv
// Shared types for the token-precision path: precision encoding (same as the A*V multiply),
// classifier FSM states, and the saturating |x| used when accumulating Q1.15 column sums.
package tva_pkg;

  typedef enum logic [1:0] {
    PREC_INT4 = 2'b00,
    PREC_INT8 = 2'b01,
    PREC_FP16 = 2'b10
  } prec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_CLASSIFY,
    ST_DONE
  } state_t;

  // -1.0 has no positive Q1.15 twin, so it clamps to the largest positive value.
  function automatic logic [15:0] abs_sat16(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    else if (v[15]) return ~v + 16'd1;
    else return v;
  endfunction

endpackage

// File: rtl/col_sum_bank.sv
// Purpose: NUM_COLS x ACC_W column-sum register file with clear, add-at-index and a read port.
// Latency: add lands on the next clock edge; the read port is combinational.
// Backpressure: none, accepts one add per cycle whenever add_en is high.
module col_sum_bank #(
  parameter int NUM_COLS = 16,
  parameter int ACC_W    = 20,
  parameter int ADD_W    = 16,
  localparam int IDX_W   = $clog2(NUM_COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [IDX_W-1:0] add_idx,
  input  logic [ADD_W-1:0] add_val,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [ACC_W-1:0] rd_sum
);

  logic [ACC_W-1:0] sums [NUM_COLS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COLS; i++) sums[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_COLS; i++) sums[i] <= '0;
    end else if (add_en) begin
      sums[add_idx] <= sums[add_idx] + ACC_W'(add_val);
    end
  end

  assign rd_sum = sums[rd_idx];

endmodule

// File: rtl/token_precision_classifier.sv
// Purpose: per-column |a| sums of the attention stream -> INT4/INT8/FP16 map; TOKEN_PREC_STATS_EN adds class counters.
// Latency: done pulses NUM_COLS cycles after the final beat handshake (one column classified per cycle).
// Backpressure: a_ready is high only while accumulating; a_valid gaps simply stall the pass.
module token_precision_classifier
  import tva_pkg::*;
#(
  parameter int A_ROWS   = 16,
  parameter int NUM_COLS = 16,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = DATA_W + $clog2(A_ROWS),
  localparam int CNT_W   = $clog2(NUM_COLS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ACC_W-1:0]          thr_hi,
  input  logic [ACC_W-1:0]          thr_lo,
  input  logic                      a_valid,
  input  logic [DATA_W-1:0]         a_data,
  output logic                      a_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      prec_valid,
`ifdef TOKEN_PREC_STATS_EN
  output logic [CNT_W-1:0]          cnt_int4,
  output logic [CNT_W-1:0]          cnt_int8,
  output logic [CNT_W-1:0]          cnt_fp16,
`endif
  output logic [NUM_COLS-1:0][1:0]  precision_sel
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int ROW_W = $clog2(A_ROWS);

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col_idx, cls_idx;
  logic [ROW_W-1:0]  row_idx;
  logic [ACC_W-1:0]  rd_sum;
  prec_t             cls_prec;
  logic              start_acc, beat, last_col, last_beat, cls_last;

  assign start_acc = (state == ST_IDLE) && start;
  assign beat      = (state == ST_ACCUM) && a_valid;
  assign last_col  = (col_idx == COL_W'(NUM_COLS - 1));
  assign last_beat = beat && last_col && (row_idx == ROW_W'(A_ROWS - 1));
  assign cls_last  = (cls_idx == COL_W'(NUM_COLS - 1));

  // thr_hi is tested first so an inverted threshold pair still resolves deterministically.
  always_comb begin
    cls_prec = PREC_INT4;
    if (rd_sum >= thr_hi)      cls_prec = PREC_FP16;
    else if (rd_sum >= thr_lo) cls_prec = PREC_INT8;
  end

  col_sum_bank #(
    .NUM_COLS (NUM_COLS),
    .ACC_W    (ACC_W),
    .ADD_W    (DATA_W)
  ) u_col_sum_bank (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_acc),
    .add_en  (beat),
    .add_idx (col_idx),
    .add_val (abs_sat16(a_data)),
    .rd_idx  (cls_idx),
    .rd_sum  (rd_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        a_ready = 1'b1;
        if (last_beat) state_nxt = ST_CLASSIFY;
      end
      ST_CLASSIFY: begin
        if (cls_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx       <= '0;
      row_idx       <= '0;
      cls_idx       <= '0;
      prec_valid    <= 1'b0;
      precision_sel <= {NUM_COLS{PREC_FP16}};
    end else begin
      if (start_acc) begin
        col_idx    <= '0;
        row_idx    <= '0;
        cls_idx    <= '0;
        prec_valid <= 1'b0;
      end
      if (beat) begin
        col_idx <= last_col ? '0 : col_idx + 1'b1;
        if (last_col) row_idx <= row_idx + 1'b1;
      end
      // prec_valid rises on the edge into DONE so it is already high alongside done.
      if (state == ST_CLASSIFY) begin
        precision_sel[cls_idx] <= cls_prec;
        cls_idx                <= cls_idx + 1'b1;
        if (cls_last) prec_valid <= 1'b1;
      end
    end
  end

`ifdef TOKEN_PREC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_int4 <= '0;
      cnt_int8 <= '0;
      cnt_fp16 <= '0;
    end else if (start_acc) begin
      cnt_int4 <= '0;
      cnt_int8 <= '0;
      cnt_fp16 <= '0;
    end else if (state == ST_CLASSIFY) begin
      case (cls_prec)
        PREC_FP16: cnt_fp16 <= cnt_fp16 + 1'b1;
        PREC_INT8: cnt_int8 <= cnt_int8 + 1'b1;
        default:   cnt_int4 <= cnt_int4 + 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_token_precision_classifier.sv
// Scoreboarded bench: expected precision maps are queued as each stream starts and checked at done.
module tb_token_precision_classifier;

  localparam int A_ROWS   = 16;
  localparam int NUM_COLS = 16;
  localparam int DATA_W   = 16;
  localparam int ACC_W    = 20;
  localparam int CNT_W    = 5;
  localparam int BEATS    = A_ROWS * NUM_COLS;

  typedef logic [NUM_COLS-1:0][1:0] map_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ACC_W-1:0]   thr_hi, thr_lo;
  logic               a_valid;
  logic [DATA_W-1:0]  a_data;
  logic               a_ready, busy, done, prec_valid;
  map_t               precision_sel;
`ifdef TOKEN_PREC_STATS_EN
  logic [CNT_W-1:0]   cnt_int4, cnt_int8, cnt_fp16;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  map_t exp_q[$];
  map_t all_fp16;

  token_precision_classifier #(
    .A_ROWS(A_ROWS), .NUM_COLS(NUM_COLS), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready), .busy(busy),
    .done(done), .prec_valid(prec_valid),
`ifdef TOKEN_PREC_STATS_EN
    .cnt_int4(cnt_int4), .cnt_int8(cnt_int8), .cnt_fp16(cnt_fp16),
`endif
    .precision_sel(precision_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] pat_val(input int pat, input int row, input int col);
    logic [15:0] v;
    v = 16'h0000;
    case (pat)
      1: v = 16'h0800;
      2: v = (col == 0) ? 16'h0100 : (col == 1) ? 16'h0400 : 16'h0000;
      3: v = 16'h8000;
      4: v = (row % 2 == 0) ? 16'(0 - col * 256) : 16'(col * 256);
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  function automatic int abs_model(input logic [15:0] v);
    if (v == 16'h8000) return 32767;
    if (v[15]) return 65536 - int'(v);
    return int'(v);
  endfunction

  function automatic map_t build_map(input int pat);
    map_t m;
    for (int c = 0; c < NUM_COLS; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < A_ROWS; r++) s += abs_model(pat_val(pat, r, c));
      if (s >= int'(thr_hi))      m[c] = 2'b10;
      else if (s >= int'(thr_lo)) m[c] = 2'b01;
      else                        m[c] = 2'b00;
    end
    return m;
  endfunction

  function automatic int count_prec(input map_t m, input logic [1:0] p);
    int n;
    n = 0;
    for (int c = 0; c < NUM_COLS; c++) if (m[c] == p) n++;
    return n;
  endfunction

  // Runs one full pass; returns what the DUT showed at done. Drives and samples on negedges.
  task automatic run_pass(input int pat, input bit gappy, input int start_at,
                          output bit seen, output int lat, output map_t m,
                          output logic pv, output logic rdy_dn, output logic done_after,
                          output logic busy_after, output logic [3*CNT_W-1:0] cnts);
    int i, guard, last_c;
    exp_q.push_back(build_map(pat));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    i = 0; guard = 0; last_c = 0;
    while (i < BEATS && guard < 4000) begin
      a_valid = gappy ? (guard % 2 == 0) : 1'b1;
      a_data  = pat_val(pat, i / NUM_COLS, i % NUM_COLS);
      start   = (i == start_at);
      if (a_valid && a_ready) begin
        i++;
        last_c = cyc;
      end
      guard++;
      @(negedge clk);
    end
    a_valid = 1'b0; start = 1'b0; a_data = '0;
    seen = 1'b0; guard = 0;
    while (!seen && guard < 100) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); guard++; end
    end
    lat    = cyc - (last_c + 1);
    m      = precision_sel;
    pv     = prec_valid;
    rdy_dn = a_ready;
`ifdef TOKEN_PREC_STATS_EN
    cnts = {cnt_int4, cnt_int8, cnt_fp16};
`else
    cnts = '0;
`endif
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  bit                 seen;
  int                 lat;
  map_t               got, expm;
  logic               pv, rdy_dn, done_after, busy_after;
  logic [3*CNT_W-1:0] cnts;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; a_data = '0;
    thr_hi = 20'h08000; thr_lo = 20'h02000;
    repeat (2) @(negedge clk);
    n_cmp++; if (precision_sel !== all_fp16) begin n_bad++; $display("FAIL reset_sel got=%h exp=%h", precision_sel, all_fp16); end
    n_cmp++; if ({done, prec_valid, a_ready, busy} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got=%b exp=0000", {done, prec_valid, a_ready, busy}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready got=%b exp=0", a_ready); end
  endtask

  task automatic test_uniform();
    run_pass(1, 1'b0, -1, seen, lat, got, pv, rdy_dn, done_after, busy_after, cnts);
    expm = exp_q.pop_front();
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL uniform_done_seen got=%b exp=1", seen); end
    n_cmp++; if (lat != NUM_COLS) begin n_bad++; $display("FAIL uniform_latency got=%0d exp=%0d", lat, NUM_COLS); end
    n_cmp++; if (got !== expm) begin n_bad++; $display("FAIL uniform_map got=%h exp=%h", got, expm); end
    n_cmp++; if (pv !== 1'b1) begin n_bad++; $display("FAIL uniform_prec_valid got=%b exp=1", pv); end
    n_cmp++; if ({done_after, busy_after} !== 2'b00) begin n_bad++; $display("FAIL uniform_done_pulse got=%b exp=00", {done_after, busy_after}); end
  endtask

  task automatic test_two_cols();
    run_pass(2, 1'b0, -1, seen, lat, got, pv, rdy_dn, done_after, busy_after, cnts);
    expm = exp_q.pop_front();
    n_cmp++; if (got !== expm) begin n_bad++; $display("FAIL two_cols_map got=%h exp=%h", got, expm); end
    n_cmp++; if (pv !== 1'b1) begin n_bad++; $display("FAIL two_cols_prec_valid got=%b exp=1", pv); end
`ifdef TOKEN_PREC_STATS_EN
    n_cmp++;
    if (cnts !== {CNT_W'(count_prec(expm, 2'b00)), CNT_W'(count_prec(expm, 2'b01)), CNT_W'(count_prec(expm, 2'b10))}) begin
      n_bad++; $display("FAIL two_cols_stats got=%h exp=int4 %0d int8 %0d fp16 %0d", cnts,
                        count_prec(expm, 2'b00), count_prec(expm, 2'b01), count_prec(expm, 2'b10));
    end
`endif
  endtask

  task automatic test_saturate();
    // start raised alongside the final beat must not disturb the pass
    run_pass(3, 1'b0, BEATS - 1, seen, lat, got, pv, rdy_dn, done_after, busy_after, cnts);
    expm = exp_q.pop_front();
    n_cmp++; if (got !== expm) begin n_bad++; $display("FAIL saturate_map got=%h exp=%h", got, expm); end
    n_cmp++; if (lat != NUM_COLS) begin n_bad++; $display("FAIL saturate_latency got=%0d exp=%0d", lat, NUM_COLS); end
  endtask

  task automatic test_gappy();
    run_pass(2, 1'b1, 40, seen, lat, got, pv, rdy_dn, done_after, busy_after, cnts);
    expm = exp_q.pop_front();
    n_cmp++; if (got !== expm) begin n_bad++; $display("FAIL gappy_map got=%h exp=%h", got, expm); end
    n_cmp++; if (lat != NUM_COLS) begin n_bad++; $display("FAIL gappy_latency got=%0d exp=%0d", lat, NUM_COLS); end
    n_cmp++; if (rdy_dn !== 1'b0) begin n_bad++; $display("FAIL gappy_ready_at_done got=%b exp=0", rdy_dn); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL gappy_idle_after got=%b exp=0", busy_after); end
    repeat (5) @(negedge clk);
    n_cmp++; if (precision_sel !== expm) begin n_bad++; $display("FAIL gappy_map_hold got=%h exp=%h", precision_sel, expm); end
  endtask

  task automatic test_negative();
    run_pass(4, 1'b0, -1, seen, lat, got, pv, rdy_dn, done_after, busy_after, cnts);
    expm = exp_q.pop_front();
    n_cmp++; if (got !== expm) begin n_bad++; $display("FAIL negative_map got=%h exp=%h", got, expm); end
  endtask

  task automatic test_reversed_thr();
    thr_hi = 20'h02000; thr_lo = 20'h08000;
    run_pass(4, 1'b0, -1, seen, lat, got, pv, rdy_dn, done_after, busy_after, cnts);
    expm = exp_q.pop_front();
    n_cmp++; if (got !== expm) begin n_bad++; $display("FAIL reversed_thr_map got=%h exp=%h", got, expm); end
    thr_hi = 20'h08000; thr_lo = 20'h02000;
  endtask

  task automatic test_reset_mid();
    int i, guard;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    i = 0; guard = 0;
    while (i < 100 && guard < 1000) begin
      a_valid = 1'b1;
      a_data  = pat_val(1, i / NUM_COLS, i % NUM_COLS);
      if (a_ready) i++;
      guard++;
      @(negedge clk);
    end
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (precision_sel !== all_fp16) begin n_bad++; $display("FAIL midreset_sel got=%h exp=%h", precision_sel, all_fp16); end
    n_cmp++; if ({prec_valid, busy, done, a_ready} !== 4'b0000) begin n_bad++; $display("FAIL midreset_flags got=%b exp=0000", {prec_valid, busy, done, a_ready}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_pass(1, 1'b0, -1, seen, lat, got, pv, rdy_dn, done_after, busy_after, cnts);
    expm = exp_q.pop_front();
    n_cmp++; if (got !== expm) begin n_bad++; $display("FAIL midreset_rerun_map got=%h exp=%h", got, expm); end
    n_cmp++; if (lat != NUM_COLS) begin n_bad++; $display("FAIL midreset_rerun_latency got=%0d exp=%0d", lat, NUM_COLS); end
  endtask

  initial begin
    for (int c = 0; c < NUM_COLS; c++) all_fp16[c] = 2'b10;
    test_reset();
    test_uniform();
    test_two_cols();
    test_saturate();
    test_gappy();
    test_negative();
    test_reversed_thr();
    test_two_cols();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
